// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RSP  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_ibuf.sv
// Fetched-instruction FIFO: push/pop/flush, flush dominates; head reads as zero when empty.
`default_nettype none

module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  ibuf_entry_t push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output ibuf_entry_t head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath; the head is masked while empty so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// PC register + single-outstanding instruction fetch with a small decode-side buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect sets sticky fetch_misaligned_o and freezes fetch.
`default_nettype none

module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_i,
  input  logic        redirect_i,
  output logic [31:0] pc_plus4_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned_o,
`endif
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         req_hs, push, pop, in_flight;
  logic         ibuf_full, ibuf_empty;
  logic [CW-1:0] ibuf_count;
  ibuf_entry_t  push_data, head;
  logic         redirect_bad, fetch_frozen;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign redirect_bad       = (next_pc_i[1:0] != 2'b00);
  assign fetch_frozen       = misaligned_q;
  assign fetch_misaligned_o = misaligned_q;
  assign misaligned_d       = misaligned_q | (redirect_i & redirect_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
`else
  assign redirect_bad = 1'b0;
  assign fetch_frozen = 1'b0;
`endif

  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req_valid_o = rst_n && (state_q == S_REQ) && !fetch_frozen
                            && (ibuf_count < CW'(IBUF_DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign pc_plus4_o       = pc_q + INSTR_BYTES;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign instr_valid_o = !ibuf_empty;
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign push_data     = '{pc: req_pc_q, instr: imem_rsp_data_i};

  // A request stays in flight past this cycle if it was just accepted or its response has not arrived.
  assign in_flight = req_hs || ((state_q != S_REQ) && !imem_rsp_valid_i);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + INSTR_BYTES;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        if (imem_rsp_valid_i) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_i) begin
      push    = 1'b0;
      pc_d    = redirect_bad ? pc_q : (next_pc_i & ~32'h3);
      state_d = in_flight ? S_DROP : S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push && !ibuf_full),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .full_o      (ibuf_full),
    .empty_o     (ibuf_empty),
    .count_o     (ibuf_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed phases push expected requests/deliveries, a monitor checks them.
`default_nettype none

module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] next_pc_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] pc_plus4_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned_o;
`endif

  pc_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IBUF_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_pc_i        (next_pc_i),
    .redirect_i       (redirect_i),
    .pc_plus4_o       (pc_plus4_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_valid_o    (instr_valid_o),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned_o (fetch_misaligned_o),
`endif
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_ins[$];

  int          mem_lat  = 1;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers each accepted request after mem_lat cycles with ~addr.
  initial begin
    forever begin
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      if (!rst_n) begin
        mem_pend = 1'b0;
      end else if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = ~mem_addr;
          mem_pend         = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      #3;
      if (!rst_n) begin
        mem_pend = 1'b0;
      end else if (imem_req_valid_o && imem_req_ready_i) begin
        mem_pend = 1'b1;
        mem_addr = imem_req_addr_o;
        mem_cnt  = mem_lat;
      end
    end
  end

  // Monitor: pops the scoreboard on every request handshake and every decode handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (imem_req_valid_o && imem_req_ready_i) begin
          if (exp_req.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: got addr %h expected no request at %0t", imem_req_addr_o, $time);
          end else begin
            e = exp_req.pop_front();
            check("req_addr", imem_req_addr_o, e);
          end
        end
        if (instr_valid_o && instr_ready_i) begin
          if (exp_ins.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_instr: got pc %h expected no delivery at %0t", instr_pc_o, $time);
          end else begin
            e = exp_ins.pop_front();
            check("instr_pc", instr_pc_o, e);
            check("instr_word", instr_o, ~e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    redirect_i       = 1'b0;
    next_pc_i        = '0;
    imem_req_ready_i = 1'b1;
    instr_ready_i    = 1'b1;
    #2;
    check("exp_req_drained", exp_req.size(), 0);
    check("exp_ins_drained", exp_ins.size(), 0);
    check("rst_req_valid", {31'd0, imem_req_valid_o}, 0);
    check("rst_instr_valid", {31'd0, instr_valid_o}, 0);
    check("rst_instr", instr_o, 0);
    check("rst_instr_pc", instr_pc_o, 0);
    check("rst_pc_plus4", pc_plus4_o, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", {31'd0, fetch_misaligned_o}, 0);
`endif
    exp_req.delete();
    exp_ins.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // Sequential fetch, stalled request, full buffer and drain.
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) exp_req.push_back(32'(i * 4));
    for (int i = 0; i < 7; i++) exp_ins.push_back(32'(i * 4));
    @(negedge clk); #2 check("lat_c1_valid", {31'd0, instr_valid_o}, 0);
    @(negedge clk); #2 check("lat_c2_valid", {31'd0, instr_valid_o}, 1);
    repeat (6) @(negedge clk);
    imem_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("stall_valid", {31'd0, imem_req_valid_o}, 1);
      check("stall_addr", imem_req_addr_o, 32'h10);
      check("stall_pc_plus4", pc_plus4_o, 32'h14);
      @(negedge clk);
    end
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("full_req_valid", {31'd0, imem_req_valid_o}, 0);
      check("full_head_valid", {31'd0, instr_valid_o}, 1);
      check("full_head_pc", instr_pc_o, 32'h10);
      check("full_head_instr", instr_o, ~32'h10);
      @(negedge clk);
    end
    instr_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    imem_req_ready_i = 1'b0;
    instr_ready_i    = 1'b0;
    repeat (2) @(negedge clk);

    // Redirect while the request for 0x8 waits for its response.
    mem_lat = 3;
    do_reset();
    exp_req.push_back(32'h0);   exp_req.push_back(32'h4);   exp_req.push_back(32'h8);
    exp_req.push_back(32'h200); exp_req.push_back(32'h204);
    exp_ins.push_back(32'h0);   exp_ins.push_back(32'h200);
    repeat (5) @(negedge clk);
    instr_ready_i = 1'b0;
    repeat (4) @(negedge clk);
    redirect_i = 1'b1;
    next_pc_i  = 32'h200;
    #2 check("pre_redirect_head_pc", instr_pc_o, 32'h4);
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #2;
    check("flush_instr_valid", {31'd0, instr_valid_o}, 0);
    check("drop_req_valid", {31'd0, imem_req_valid_o}, 0);
    @(negedge clk); #2 check("drop_rsp_instr_valid", {31'd0, instr_valid_o}, 0);
    @(negedge clk);
    #2;
    check("after_drop_addr", imem_req_addr_o, 32'h200);
    check("after_drop_instr_valid", {31'd0, instr_valid_o}, 0);
    repeat (5) @(negedge clk);
    imem_req_ready_i = 1'b0;
    instr_ready_i    = 1'b0;
    repeat (2) @(negedge clk);

    // Redirect on a request handshake, then fetch across the 32-bit wrap.
    mem_lat = 1;
    do_reset();
    redirect_i = 1'b1;
    next_pc_i  = 32'hFFFF_FFF8;
    exp_req.push_back(32'h0);         exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_ins.push_back(32'hFFFF_FFF8); exp_ins.push_back(32'hFFFF_FFFC);
    exp_ins.push_back(32'h0);
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    check("hs_redirect_instr_valid", {31'd0, instr_valid_o}, 0);
    check("hs_redirect_req_valid", {31'd0, imem_req_valid_o}, 0);
    repeat (3) @(negedge clk);
    #2;
    check("wrap_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4_o, 32'h0);
    repeat (5) @(negedge clk);
    imem_req_ready_i = 1'b0;
    instr_ready_i    = 1'b0;
    repeat (2) @(negedge clk);

    // Misaligned redirect target.
    mem_lat = 1;
    do_reset();
    imem_req_ready_i = 1'b0;
    redirect_i       = 1'b1;
    next_pc_i        = 32'h102;
    @(negedge clk);
    redirect_i       = 1'b0;
    imem_req_ready_i = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      #2;
      check("trap_misaligned", {31'd0, fetch_misaligned_o}, 1);
      check("trap_req_valid", {31'd0, imem_req_valid_o}, 0);
      check("trap_pc_plus4", pc_plus4_o, 32'h4);
      @(negedge clk);
    end
`else
    exp_req.push_back(32'h100);
    exp_ins.push_back(32'h100);
    #2;
    check("align_addr", imem_req_addr_o, 32'h100);
    check("align_pc_plus4", pc_plus4_o, 32'h104);
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    instr_ready_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("final_exp_req_drained", exp_req.size(), 0);
    check("final_exp_ins_drained", exp_ins.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
